// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART <-> ALU sequencer.
package uart_alu_pkg;

  localparam int unsigned NB_STATE = 3;

  typedef enum logic [NB_STATE-1:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_WAIT_TX = 3'd4
  } state_t;

  // ALU opcodes (low 6 bits of the opcode byte)
  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;

endpackage

// File: rtl/uart_alu_ctrl_frame_timeout_ctr.sv
// Inter-byte timeout counter: counts enabled cycles, pulses expire on the
// last allowed cycle and wraps to zero so the next frame starts clean.
module frame_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 260420
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expire = enable && (count == LAST);

  // Count idle cycles; clear on accepted byte, outside the timed states, or on expiry
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Sequencer: gathers A, B, opcode bytes from the UART receiver, presents them
// to the ALU, then sends the ALU result back through the UART transmitter.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 260420
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done_tick,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_frame_err,
  output logic               o_overrun
);

  state_t state, state_next;
  logic   ld_a, ld_b, ld_op, ld_tx;
  logic   frame_err_next, overrun_next;
  logic   timed_state, to_enable, to_clear, to_expire;

  assign timed_state = (state == S_WAIT_B) || (state == S_WAIT_OP);
  // The counter only runs on idle cycles of a partial frame; a tick clears it,
  // which is also what makes a tick win over a coinciding expiry.
  assign to_enable   = timed_state && !i_rx_done_tick;
  assign to_clear    = !to_enable;
  assign o_busy      = (state == S_EXEC) || (state == S_WAIT_TX);

  frame_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (i_clk),
    .reset  (i_reset),
    .clear  (to_clear),
    .enable (to_enable),
    .expire (to_expire)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_WAIT_A;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and register load strobes
  always_comb begin
    state_next     = state;
    ld_a           = 1'b0;
    ld_b           = 1'b0;
    ld_op          = 1'b0;
    ld_tx          = 1'b0;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;
    case (state)
      S_WAIT_A: begin
        if (i_rx_done_tick) begin
          ld_a       = 1'b1;
          state_next = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (i_rx_done_tick) begin
          ld_b       = 1'b1;
          state_next = S_WAIT_OP;
        end else if (to_expire) begin
          frame_err_next = 1'b1;
          state_next     = S_WAIT_A;
        end
      end
      S_WAIT_OP: begin
        if (i_rx_done_tick) begin
          ld_op      = 1'b1;
          state_next = S_EXEC;
        end else if (to_expire) begin
          frame_err_next = 1'b1;
          state_next     = S_WAIT_A;
        end
      end
      S_EXEC: begin
        ld_tx        = 1'b1;
        overrun_next = i_rx_done_tick;
        state_next   = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        overrun_next = i_rx_done_tick;
        if (i_tx_done_tick) begin
          state_next = S_WAIT_A;
        end
      end
      default: state_next = S_WAIT_A;
    endcase
  end

  // Registered ALU inputs, transmit byte and status pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_alu_op    <= '0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (ld_a)  o_alu_a  <= i_rx_data;
      if (ld_b)  o_alu_b  <= i_rx_data;
      if (ld_op) o_alu_op <= i_rx_data[NB_OP-1:0];
      if (ld_tx) o_tx_data <= i_alu_result;
      o_tx_start  <= ld_tx;
      o_frame_err <= frame_err_next;
      o_overrun   <= overrun_next;
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl with a small behavioural ALU.
module tb_uart_alu_ctrl;
  import uart_alu_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx_done_tick = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_tx_done_tick = 1'b0;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_frame_err, o_overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  uart_alu_ctrl #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_rx_done_tick (i_rx_done_tick),
    .i_rx_data      (i_rx_data),
    .i_tx_done_tick (i_tx_done_tick),
    .i_alu_result   (i_alu_result),
    .o_alu_a        (o_alu_a),
    .o_alu_b        (o_alu_b),
    .o_alu_op       (o_alu_op),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .o_busy         (o_busy),
    .o_frame_err    (o_frame_err),
    .o_overrun      (o_overrun)
  );

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [5:0] op);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      NOR:     return ~(a | b);
      SRA:     return 8'($signed(a) >>> b);
      SRL:     return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb i_alu_result = alu(o_alu_a, o_alu_b, o_alu_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_done_tick = 1'b1;
    i_rx_data      = b;
    step();
    i_rx_done_tick = 1'b0;
  endtask

  task automatic tx_done();
    i_tx_done_tick = 1'b1;
    step();
    i_tx_done_tick = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},     o_alu_a, 0);
    check({tag, "_b"},     o_alu_b, 0);
    check({tag, "_op"},    o_alu_op, 0);
    check({tag, "_start"}, o_tx_start, 0);
    check({tag, "_txd"},   o_tx_data, 0);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_ferr"},  o_frame_err, 0);
    check({tag, "_ovr"},   o_overrun, 0);
  endtask

  initial begin
    int pulses;
    int at;

    // Reset state
    step();
    step();
    check_all_zero("rst");
    i_reset = 1'b0;
    step();

    // 1: ADD 5 + 3
    send(8'h05);
    check("t1_a", o_alu_a, 8'h05);
    check("t1_busy_a", o_busy, 0);
    send(8'h03);
    check("t1_b", o_alu_b, 8'h03);
    send(8'h20);
    check("t1_op", o_alu_op, 6'h20);
    check("t1_busy_exec", o_busy, 1);
    check("t1_start_exec", o_tx_start, 0);
    step();
    check("t1_start", o_tx_start, 1);
    check("t1_txd", o_tx_data, 8'h08);
    step();
    check("t1_start_low", o_tx_start, 0);
    check("t1_busy_tx", o_busy, 1);
    step();
    step();
    check("t1_busy_hold", o_busy, 1);
    tx_done();
    check("t1_busy_done", o_busy, 0);

    // 2: opcode byte 0xE2 -> SUB
    send(8'h10);
    send(8'h01);
    send(8'hE2);
    check("t2_op", o_alu_op, 6'h22);
    step();
    check("t2_start", o_tx_start, 1);
    check("t2_txd", o_tx_data, 8'h0F);
    tx_done();

    // 3: partial frame then silence
    send(8'h7F);
    pulses = 0;
    at = 0;
    for (int k = 1; k <= 105; k++) begin
      step();
      if (o_frame_err) begin
        pulses++;
        at = k;
      end
    end
    check("t3_err_count", pulses, 1);
    check("t3_err_cycle", at, 100);
    check("t3_busy", o_busy, 0);
    send(8'h02);
    check("t3_restart_a", o_alu_a, 8'h02);
    check("t3_b_kept", o_alu_b, 8'h01);
    send(8'h03);
    send(8'h20);
    step();
    check("t3_txd", o_tx_data, 8'h05);
    tx_done();

    // 4: tick lands in the last allowed cycle
    send(8'h09);
    pulses = 0;
    for (int k = 1; k <= 99; k++) begin
      step();
      if (o_frame_err) pulses++;
    end
    send(8'h04);
    if (o_frame_err) pulses++;
    check("t4_b", o_alu_b, 8'h04);
    send(8'h25);
    if (o_frame_err) pulses++;
    check("t4_no_err", pulses, 0);
    check("t4_op", o_alu_op, 6'h25);
    step();
    check("t4_txd", o_tx_data, 8'h0D);

    // 5: byte arrives while transmitting
    send(8'hAA);
    check("t5_ovr", o_overrun, 1);
    check("t5_a", o_alu_a, 8'h09);
    check("t5_b", o_alu_b, 8'h04);
    check("t5_op", o_alu_op, 6'h25);
    check("t5_busy", o_busy, 1);
    step();
    check("t5_ovr_low", o_overrun, 0);
    tx_done();
    send(8'hF0);
    send(8'h04);
    send(8'h03);
    check("t5_next_a", o_alu_a, 8'hF0);
    step();
    check("t5_sra", o_tx_data, 8'hFF);
    tx_done();

    // 6: reset mid-frame and mid-transmission
    send(8'h11);
    send(8'h22);
    i_reset = 1'b1;
    step();
    check_all_zero("t6a");
    i_reset = 1'b0;
    send(8'h33);
    send(8'h11);
    send(8'h26);
    step();
    check("t6_txd_xor", o_tx_data, 8'h22);
    step();
    i_reset = 1'b1;
    step();
    check_all_zero("t6b");
    i_reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (o_tx_start) pulses++;
    end
    check("t6_no_restart", pulses, 0);
    send(8'h0F);
    send(8'h30);
    send(8'h27);
    step();
    check("t6_start", o_tx_start, 1);
    check("t6_nor", o_tx_data, 8'hC0);
    tx_done();
    check("t6_idle", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
